circuit_delay_model: RTL and testbench

- Clocked delay-line block: one data input `d`, three tapped outputs.
- `q1`, `q2`, `q3` are copies of `d` delayed by a fixed, parameterised number of clock cycles (default 1, 2, 3).
- Used as the reference timing model for register-stage latency in the datapath, and as a pipeline-alignment utility.

---
 rtl/delay_model_pkg.sv | 17 +
 rtl/delay_stage.sv | 31 +++
 rtl/circuit_delay_model.sv | 44 ++++
 tb/tb_circuit_delay_model.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/delay_model_pkg.sv
// Shared defaults and helpers for the circuit_delay_model delay line.
package delay_model_pkg;

  localparam int DEF_WIDTH     = 1;
  localparam int DEF_TAP1      = 1;
  localparam int DEF_TAP2      = 2;
  localparam int DEF_TAP3      = 3;
  localparam int DEF_RESET_VAL = 0;

  typedef logic [DEF_WIDTH-1:0] data_t;

  // Taps must start at one and never decrease along the line.
  function automatic bit taps_legal(input int t1, input int t2, input int t3);
    return (t1 >= 1) && (t2 >= t1) && (t3 >= t2);
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One register of the delay line, flushed to RESET_VAL on a synchronous reset.
module delay_stage
  import delay_model_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_d;
  logic [WIDTH-1:0] data_q;

  always_comb begin
    data_d = d;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      data_q <= RESET_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/circuit_delay_model.sv
// Tapped delay line: TAP3 chained registers with outputs at TAP1, TAP2 and TAP3.
module circuit_delay_model
  import delay_model_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               TAP1      = DEF_TAP1,
  parameter int               TAP2      = DEF_TAP2,
  parameter int               TAP3      = DEF_TAP3,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DEF_RESET_VAL)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3
);

  if (!taps_legal(TAP1, TAP2, TAP3)) begin : g_bad_taps
    $fatal(1, "circuit_delay_model: taps must satisfy 1 <= TAP1 <= TAP2 <= TAP3");
  end

  // stage[0] is the raw input; stage[k] is the output of register k.
  logic [WIDTH-1:0] stage [0:TAP3];

  assign stage[0] = d;

  for (genvar k = 1; k <= TAP3; k++) begin : g_stage
    delay_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk  (clk),
      .rstn (rstn),
      .d    (stage[k-1]),
      .q    (stage[k])
    );
  end

  assign q1 = stage[TAP1];
  assign q2 = stage[TAP2];
  assign q3 = stage[TAP3];

endmodule

// File: tb/tb_circuit_delay_model.sv
// Directed bench for circuit_delay_model: default 1/2/3 taps and an 8-bit 2/2/5 build.
module tb_circuit_delay_model;

  logic       clk = 1'b0;
  logic       rstn;
  logic       d;
  logic       q1, q2, q3;
  logic [7:0] dw;
  logic [7:0] qw1, qw2, qw3;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  circuit_delay_model dut (
    .clk  (clk),
    .rstn (rstn),
    .d    (d),
    .q1   (q1),
    .q2   (q2),
    .q3   (q3)
  );

  circuit_delay_model #(
    .WIDTH     (8),
    .TAP1      (2),
    .TAP2      (2),
    .TAP3      (5),
    .RESET_VAL (8'h00)
  ) dut_w (
    .clk  (clk),
    .rstn (rstn),
    .d    (dw),
    .q1   (qw1),
    .q2   (qw2),
    .q3   (qw3)
  );

  typedef struct {
    string      name;
    logic       rstn;
    logic       d;
    logic [2:0] exp;   // {q1, q2, q3} after the edge
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic r, input logic dv, input logic [2:0] e);
    vec_t v;
    v.name = name;
    v.rstn = r;
    v.d    = dv;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b1;
    d    = 1'b1;
    dw   = 8'h00;

    // Reset hold with d = 1
    add("reset_hold0", 1, 1, 3'b000);
    add("reset_hold1", 1, 1, 3'b000);
    add("reset_hold2", 1, 1, 3'b000);
    // Step response
    add("step1", 0, 1, 3'b100);
    add("step2", 0, 1, 3'b110);
    add("step3", 0, 1, 3'b111);
    add("step4", 0, 1, 3'b111);
    add("drain1", 0, 0, 3'b011);
    add("drain2", 0, 0, 3'b001);
    add("drain3", 0, 0, 3'b000);
    // Single-cycle pulse
    add("pulse1", 0, 1, 3'b100);
    add("pulse2", 0, 0, 3'b010);
    add("pulse3", 0, 0, 3'b001);
    add("pulse4", 0, 0, 3'b000);
    // Pattern 1,0,1,1,0,1,1,0,1 then flush
    add("pat0", 0, 1, 3'b100);
    add("pat1", 0, 0, 3'b010);
    add("pat2", 0, 1, 3'b101);
    add("pat3", 0, 1, 3'b110);
    add("pat4", 0, 0, 3'b011);
    add("pat5", 0, 1, 3'b101);
    add("pat6", 0, 1, 3'b110);
    add("pat7", 0, 0, 3'b011);
    add("pat8", 0, 1, 3'b101);
    add("pat9", 0, 0, 3'b010);
    add("pat10", 0, 0, 3'b001);
    add("pat11", 0, 0, 3'b000);
    // Fill, mid-stream reset, refill
    add("fill1", 0, 1, 3'b100);
    add("fill2", 0, 1, 3'b110);
    add("fill3", 0, 1, 3'b111);
    add("mid_rst", 1, 1, 3'b000);
    add("refill1", 0, 1, 3'b100);
    add("refill2", 0, 1, 3'b110);
    add("refill3", 0, 1, 3'b111);

    foreach (vecs[i]) begin
      rstn = vecs[i].rstn;
      d    = vecs[i].d;
      tick();
      check(vecs[i].name, {5'b0, q1, q2, q3}, {5'b0, vecs[i].exp});
    end

    // Wide build: reset, then 0xA5 for one cycle followed by 0x3C held
    rstn = 1'b1;
    d    = 1'b0;
    dw   = 8'hFF;
    tick();
    check("w_rst_q1", qw1, 8'h00);
    check("w_rst_q3", qw3, 8'h00);

    rstn = 1'b0;
    dw   = 8'hA5;
    tick();
    check("w_e1_q1", qw1, 8'h00);
    check("w_e1_q3", qw3, 8'h00);

    dw = 8'h3C;
    tick();
    check("w_e2_q1", qw1, 8'hA5);
    check("w_e2_q2", qw2, 8'hA5);
    check("w_e2_q3", qw3, 8'h00);

    tick();
    check("w_e3_q1", qw1, 8'h3C);
    check("w_e3_q2", qw2, 8'h3C);

    tick();
    check("w_e4_q3", qw3, 8'h00);

    tick();
    check("w_e5_q3", qw3, 8'hA5);

    tick();
    check("w_e6_q3", qw3, 8'h3C);
    check("w_e6_q1", qw1, 8'h3C);

    // Mid-stream reset on the wide build flushes every stage
    rstn = 1'b1;
    tick();
    check("w_mid_rst_q1", qw1, 8'h00);
    check("w_mid_rst_q3", qw3, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
